scrambler_stream_xor: RTL and testbench

//  Keystream consumer sitting directly downstream of the primary 86-bit LFSR.
//  - XORs each accepted data beat with the top DATA_WIDTH bits of the LFSR state.
//  - Pulses the LFSR advance strobe once per accepted beat.
//  - Stalls the stream while software reloads the LFSR seed over the register bus.
//  - Valid/ready stream in and out, 2-entry output skid buffer, full throughput.

---
 rtl/scr_pkg.sv | 29 ++
 rtl/scr_skid_buf.sv | 68 ++++++
 rtl/scrambler_stream_xor.sv | 161 ++++++++++++++++
 tb/tb_scrambler_stream_xor.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr_pkg.sv
// Package: scr_pkg
// Shared definitions for the scrambler stream XOR block.
//   - Default widths of the LFSR state and of a data beat.
//   - Register bus addresses of the three seed words and the control word.
//   - Stream controller state enum.
//   - Helper that recognises a seed-word address.
// Optional feature macro used by the top: SCR_BEAT_CNT_EN (beat counter).
package scr_pkg;

  localparam int DEF_POLY_WIDTH = 86;
  localparam int DEF_DATA_WIDTH = 14;

  localparam logic [11:0] LFSR_W0 = 12'h0d4;
  localparam logic [11:0] LFSR_W1 = 12'h0d5;
  localparam logic [11:0] LFSR_W2 = 12'h0d6;
  localparam logic [11:0] CTRL    = 12'h0d7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } scr_state_t;

  // Any of the three seed words counts as a seed reload.
  function automatic logic is_seed_addr(input logic [11:0] a);
    return (a == LFSR_W0) || (a == LFSR_W1) || (a == LFSR_W2);
  endfunction

endpackage

// File: rtl/scr_skid_buf.sv
// Module: scr_skid_buf
// Two-entry FIFO skid buffer on the output side of the scrambler.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push         write i_data this cycle (caller guarantees not full)
//   i_data         beat to store
//   i_out_ready    downstream ready; a pop happens on o_valid & i_out_ready
//   o_valid        buffer holds at least one beat
//   o_data         oldest beat
//   o_free_next    at least one entry will be free after this cycle
module scr_skid_buf
  import scr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_out_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_free_next
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_pop;
  logic [1:0]            w_count_next;

  assign o_valid     = (r_count != 2'd0);
  assign o_data      = r_mem[r_rd_ptr];
  assign w_pop       = o_valid && i_out_ready;
  assign o_free_next = (w_count_next != 2'd2);

  // Occupancy for the next cycle; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (i_push && !w_pop) begin
      w_count_next = r_count + 2'd1;
    end else if (w_pop && !i_push) begin
      w_count_next = r_count - 2'd1;
    end
  end

  // Storage and pointers; entries are cleared on reset so o_data reads zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/scrambler_stream_xor.sv
// Module: scrambler_stream_xor
// Keystream consumer downstream of the 86-bit LFSR. Each accepted beat is XORed
// with the top DATA_WIDTH bits of the LFSR state (or passed through in bypass),
// and the LFSR is told to advance one block per scrambled beat. The stream is
// stalled while software reloads the seed over the register bus.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_write/i_addr/i_wdata    shared register bus (seed words 0x0d4..0x0d6, ctrl)
//   i_lfsr_dout               current LFSR state
//   o_lfsr_enable             advance the LFSR by DATA_WIDTH steps
//   i_in_valid/i_in_data/o_in_ready      plaintext stream
//   o_out_valid/o_out_data/i_out_ready   scrambled stream
//   o_beat_cnt                accepted-beat counter (only with SCR_BEAT_CNT_EN)
// Optional feature macro: SCR_BEAT_CNT_EN.
module scrambler_stream_xor
  import scr_pkg::*;
#(
  parameter int          POLY_WIDTH = DEF_POLY_WIDTH,
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [11:0] CTRL_ADDR  = CTRL
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_write,
  input  logic [11:0]           i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [POLY_WIDTH-1:0] i_lfsr_dout,
  output logic                  o_lfsr_enable,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  input  logic                  i_out_ready
`ifdef SCR_BEAT_CNT_EN
  ,
  output logic [31:0]           o_beat_cnt
`endif
);

  scr_state_t            r_state;
  scr_state_t            w_state_next;
  logic [1:0]            r_ctrl;
  logic [1:0]            w_ctrl_next;
  logic                  r_in_ready;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_lfsr_en;
  logic                  w_seed_wr;
  logic                  w_ctrl_wr;
  logic                  w_free_next;
  logic [DATA_WIDTH-1:0] w_key;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_unused_bits;

  assign w_seed_wr = i_write && is_seed_addr(i_addr);
  assign w_ctrl_wr = i_write && (i_addr == CTRL_ADDR);
  assign w_key     = i_lfsr_dout[POLY_WIDTH-1 -: DATA_WIDTH];

  assign w_unused_bits = ^{i_lfsr_dout[POLY_WIDTH-DATA_WIDTH-1:0], i_wdata[31:2]};

  assign o_in_ready    = w_in_ready;
  assign o_lfsr_enable = w_lfsr_en;

  // A ctrl write takes effect on the state decision in the same cycle, so a
  // ctrl write during LOAD steers where LOAD exits to.
  always_comb begin
    w_ctrl_next = r_ctrl;
    if (w_ctrl_wr) begin
      w_ctrl_next = i_wdata[1:0];
    end
  end

  // Control register: bit0 scrambling on, bit1 bypass.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl <= 2'b00;
    end else if (w_ctrl_wr) begin
      r_ctrl <= i_wdata[1:0];
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and stream datapath. LOAD lasts one settling cycle after the last
  // seed write. The registered ready is additionally masked by a seed write in
  // the same cycle so that an advance can never coincide with a seed load.
  // Bypass wins when both ctrl bits are set.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_lfsr_en    = 1'b0;
    w_result     = i_in_data;
    case (r_state)
      IDLE, RUN, LOAD: begin
        if (w_seed_wr) begin
          w_state_next = LOAD;
        end else if (w_ctrl_next != 2'b00) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_in_ready = r_in_ready && !w_seed_wr;
    w_accept   = i_in_valid && w_in_ready;
    w_lfsr_en  = w_accept && r_ctrl[0] && !r_ctrl[1];
    if (!r_ctrl[1]) begin
      w_result = i_in_data ^ w_key;
    end
  end

  // Ready is registered from the state and skid occupancy we will have next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_next == RUN) && w_free_next;
    end
  end

  scr_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_accept),
    .i_data      (w_result),
    .i_out_ready (i_out_ready),
    .o_valid     (o_out_valid),
    .o_data      (o_out_data),
    .o_free_next (w_free_next)
  );

`ifdef SCR_BEAT_CNT_EN
  logic [31:0] r_beat_cnt;

  // Accepted-beat counter; wraps naturally and restarts on any seed reload.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat_cnt <= '0;
    end else if (w_seed_wr) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign o_beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_scrambler_stream_xor.sv
// Testbench: tb_scrambler_stream_xor
// Drives scrambler_stream_xor from a stand-in 86-bit LFSR and checks every output
// beat against a reference keystream kept in the bench.
// Optional feature macro: SCR_BEAT_CNT_EN (beat counter checks).
module tb_scrambler_stream_xor;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [85:0] lfsr = '0;
  logic        inValid;
  logic [13:0] inData;
  logic        outReady;
  logic        lfsrEnable;
  logic        inReady;
  logic        outValid;
  logic [13:0] outData;
`ifdef SCR_BEAT_CNT_EN
  logic [31:0] beatCnt;
`endif

  int          checks   = 0;
  int          errors   = 0;
  int          enPulses = 0;
  logic [13:0] expQ[$];
  logic [85:0] modelState = '0;
  logic [1:0]  ctrlModel  = 2'b00;
  logic        sInReady;
  logic        sEn;
  logic        sOutValid;
  logic [13:0] sOutData;

  always #5 clk = ~clk;

  scrambler_stream_xor dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_write       (write),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .i_lfsr_dout   (lfsr),
    .o_lfsr_enable (lfsrEnable),
    .i_in_valid    (inValid),
    .i_in_data     (inData),
    .o_in_ready    (inReady),
    .o_out_valid   (outValid),
    .o_out_data    (outData),
    .i_out_ready   (outReady)
`ifdef SCR_BEAT_CNT_EN
    ,
    .o_beat_cnt    (beatCnt)
`endif
  );

  // Serial LFSR, first output bit at the MSB; one advance is 14 serial steps.
  function automatic logic [85:0] lfsrAdvance(input logic [85:0] s);
    logic [85:0] v;
    v = s;
    for (int i = 0; i < 14; i++) begin
      v = {v[84:0], v[85] ^ v[84] ^ v[74] ^ v[73]};
    end
    return v;
  endfunction

  // Stand-in for the real LFSR: advance has priority over a seed load.
  always @(posedge clk) begin
    if (lfsrEnable) begin
      lfsr <= lfsrAdvance(lfsr);
    end else if (write) begin
      case (addr)
        12'h0d4: lfsr[31:0]  <= wdata;
        12'h0d5: lfsr[63:32] <= wdata;
        12'h0d6: lfsr[85:64] <= wdata[21:0];
        default: ;
      endcase
    end
  end

  // One clock: sample at the falling edge, update the reference, return just
  // after the next rising edge so the caller can drive new inputs.
  task automatic tick();
    logic        scr;
    logic [13:0] expData;
    @(negedge clk);
    sInReady  = inReady;
    sEn       = lfsrEnable;
    sOutValid = outValid;
    sOutData  = outData;
    if (rst) begin
      expQ.delete();
      ctrlModel = 2'b00;
    end else begin
      if (sEn) enPulses++;
      if (inValid && sInReady) begin
        scr     = ctrlModel[0] && !ctrlModel[1];
        expData = scr ? (inData ^ modelState[85:72]) : inData;
        checks++;
        if (sEn !== scr) begin
          errors++;
          $display("[TB] FAIL accept_enable got=%b expected=%b", sEn, scr);
        end
        expQ.push_back(expData);
        if (scr) modelState = lfsrAdvance(modelState);
      end else begin
        checks++;
        if (sEn !== 1'b0) begin
          errors++;
          $display("[TB] FAIL idle_enable got=%b expected=0", sEn);
        end
      end
      if (sOutValid && outReady) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL out_unexpected got=%h expected=no beat", sOutData);
        end else begin
          expData = expQ.pop_front();
          if (sOutData !== expData) begin
            errors++;
            $display("[TB] FAIL out_data got=%h expected=%h", sOutData, expData);
          end
        end
      end
      if (write) begin
        case (addr)
          12'h0d4: modelState[31:0]  = wdata;
          12'h0d5: modelState[63:32] = wdata;
          12'h0d6: modelState[85:64] = wdata[21:0];
          12'h0d7: ctrlModel         = wdata[1:0];
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic regWrite(input logic [11:0] a, input logic [31:0] d);
    write = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    write = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic sendBeat(input logic [13:0] d, output bit ok);
    ok      = 1'b0;
    inValid = 1'b1;
    inData  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (sInReady) ok = 1'b1;
    end
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (sInReady !== 1'b0 || sOutValid !== 1'b0 || sOutData !== 14'h0 || sEn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got=rdy%b vld%b data%h en%b expected=rdy0 vld0 data0000 en0",
               sInReady, sOutValid, sOutData, sEn);
    end
    inValid = 1'b1;
    inData  = 14'h1555;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sInReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_ready got=%b expected=0", sInReady);
      end
    end
    inValid = 1'b0;
  endtask

  task automatic test_first_beat();
    int en0;
    bit ok;
    bit seen;
    outReady = 1'b1;
    regWrite(12'h0d4, 32'h0);
    regWrite(12'h0d5, 32'h0);
    regWrite(12'h0d6, 32'h0020_0000);
    regWrite(12'h0d7, 32'h1);
    en0 = enPulses;
    sendBeat(14'h0000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL first_accept got=timeout expected=accepted");
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (sOutValid) begin
        seen = 1'b1;
        checks++;
        if (sOutData !== 14'h2000) begin
          errors++;
          $display("[TB] FAIL first_out got=%h expected=2000", sOutData);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL first_out got=timeout expected=2000");
    end
    tick();
    tick();
    checks++;
    if (enPulses - en0 !== 1) begin
      errors++;
      $display("[TB] FAIL first_enable_pulses got=%0d expected=1", enPulses - en0);
    end
  endtask

  task automatic test_back_to_back();
    outReady = 1'b1;
    inValid  = 1'b1;
    inData   = 14'($urandom);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8) begin
        checks++;
        if (sInReady !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_ready cycle=%0d got=%b expected=1", i, sInReady);
        end
      end
      if (i > 0) begin
        checks++;
        if (sOutValid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_out_valid cycle=%0d got=%b expected=1", i, sOutValid);
        end
      end
      if (i == 7) inValid = 1'b0;
      else        inData  = 14'($urandom);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [13:0] d [3];
    int          k;
    bit          got3;
    for (int i = 0; i < 3; i++) d[i] = 14'($urandom);
    outReady = 1'b0;
    k        = 0;
    inValid  = 1'b1;
    inData   = d[0];
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sInReady) begin
        k++;
        if (k < 3) inData = d[k];
      end
    end
    checks++;
    if (k !== 2) begin
      errors++;
      $display("[TB] FAIL bp_accepted got=%0d expected=2", k);
    end
    tick();
    checks++;
    if (sInReady !== 1'b0 || sEn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_full got=rdy%b en%b expected=rdy0 en0", sInReady, sEn);
    end
    outReady = 1'b1;
    got3     = 1'b0;
    for (int i = 0; i < 10 && !got3 && k < 3; i++) begin
      tick();
      if (sInReady) got3 = 1'b1;
    end
    inValid = 1'b0;
    checks++;
    if (!got3) begin
      errors++;
      $display("[TB] FAIL bp_third_accept got=timeout expected=accepted");
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_seed_midstream();
    logic rdy [8];
    logic en  [8];
    outReady = 1'b1;
    inValid  = 1'b1;
    inData   = 14'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        write = 1'b1;
        addr  = 12'h0d5;
        wdata = $urandom;
      end
      tick();
      rdy[i] = sInReady;
      en[i]  = sEn;
      write  = 1'b0;
      addr   = '0;
      wdata  = '0;
      if (sInReady) inData = 14'($urandom);
    end
    inValid = 1'b0;
    checks++;
    if (rdy[1] !== 1'b1 || rdy[2] !== 1'b0 || rdy[3] !== 1'b0 || rdy[4] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL seed_ready got=%b%b%b%b expected=1001", rdy[1], rdy[2], rdy[3], rdy[4]);
    end
    checks++;
    if (en[2] !== 1'b0 || en[3] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seed_enable got=%b%b expected=00", en[2], en[3]);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_bypass();
    logic [85:0] saved;
    bit          ok;
    outReady = 1'b1;
    regWrite(12'h0d7, 32'h2);
    saved = lfsr;
    for (int i = 0; i < 4; i++) begin
      sendBeat(14'($urandom), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL bypass_accept got=timeout expected=accepted");
      end
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (lfsr !== saved) begin
      errors++;
      $display("[TB] FAIL bypass_lfsr got=%h expected=%h", lfsr, saved);
    end
  endtask

  task automatic test_reset_full();
    bit ok;
    outReady = 1'b0;
    regWrite(12'h0d7, 32'h1);
    sendBeat(14'($urandom), ok);
    sendBeat(14'($urandom), ok);
    tick();
    checks++;
    if (sOutValid !== 1'b1 || sInReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_before_reset got=vld%b rdy%b expected=vld1 rdy0", sOutValid, sInReady);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (sOutValid !== 1'b0 || sOutData !== 14'h0 || sInReady !== 1'b0 || sEn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_values got=vld%b data%h rdy%b en%b expected=vld0 data0000 rdy0 en0",
               sOutValid, sOutData, sInReady, sEn);
    end
    inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sInReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_idle got=%b expected=0", sInReady);
      end
    end
    inValid = 1'b0;
`ifdef SCR_BEAT_CNT_EN
    checks++;
    if (beatCnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL cnt_reset got=%0d expected=0", beatCnt);
    end
    outReady = 1'b1;
    regWrite(12'h0d7, 32'h1);
    for (int i = 0; i < 5; i++) sendBeat(14'($urandom), ok);
    checks++;
    if (beatCnt !== 32'd5) begin
      errors++;
      $display("[TB] FAIL cnt_five got=%0d expected=5", beatCnt);
    end
    regWrite(12'h0d4, $urandom);
    checks++;
    if (beatCnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL cnt_seed_clear got=%0d expected=0", beatCnt);
    end
`endif
    outReady = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    rst      = 1'b1;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;
    test_reset();
    test_first_beat();
    test_back_to_back();
    test_backpressure();
    test_seed_midstream();
    test_bypass();
    test_reset_full();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got=%0d pending expected=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
